// File: rtl/seven_seg_mux.sv
// Four-digit common-anode seven-segment scanner: a free-running refresh counter
// selects one digit at a time and decodes its live hex value onto the segment bus.
module seven_seg_mux #(
  parameter int N = 18
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       dp,
  output logic [3:0] an
);

  logic [N-1:0] count_reg;
  logic [1:0]   sel;
  logic [3:0]   digit;
  logic [6:0]   seg;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign sel = count_reg[N-1:N-2];

  // One-cold anodes: each bit goes low only while its own digit is selected.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_anode
      assign an[gi] = (sel != 2'(gi));
    end
  endgenerate

  always_comb begin
    digit = in0;
    case (sel)
      2'd0: digit = in0;
      2'd1: digit = in1;
      2'd2: digit = in2;
      2'd3: digit = in3;
      default: digit = in0;
    endcase
  end

  // Active-low segment patterns, bit order {a,b,c,d,e,f,g}.
  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'b1111111;
    endcase
  end

  assign {a, b, c, d, e, f, g} = seg;
  assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux with N=4: scan order, decode table, live
// input tracking, mid-scan reset and the one-cold anode invariant.
module tb_seven_seg_mux;

  logic       clock;
  logic       reset;
  logic [3:0] in0, in1, in2, in3;
  logic       a, b, c, d, e, f, g, dp;
  logic [3:0] an;
  logic [6:0] segs;

  int checks;
  int errors;

  seven_seg_mux #(.N(4)) dut (
    .clock(clock), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
    .dp(dp), .an(an)
  );

  assign segs = {a, b, c, d, e, f, g};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Apply reset across one rising edge; on return count is 0 and reset is low.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    in0 = 4'h0; in1 = 4'h1; in2 = 4'h2; in3 = 4'h3;
    do_reset();
    #1;
    checks++;
    if (an !== 4'b1110 || segs !== 7'b0000001 || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: an=%b segs=%b dp=%b, want an=1110 segs=0000001 dp=1", an, segs, dp);
    end
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (an !== 4'b1101 || segs !== 7'b1001111) begin
      errors++;
      $display("FAIL scan_digit1: an=%b segs=%b, want an=1101 segs=1001111", an, segs);
    end
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (an !== 4'b1011 || segs !== 7'b0010010) begin
      errors++;
      $display("FAIL scan_digit2: an=%b segs=%b, want an=1011 segs=0010010", an, segs);
    end
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (an !== 4'b0111 || segs !== 7'b0000110) begin
      errors++;
      $display("FAIL scan_digit3: an=%b segs=%b, want an=0111 segs=0000110", an, segs);
    end
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (an !== 4'b1110 || segs !== 7'b0000001) begin
      errors++;
      $display("FAIL scan_wrap: an=%b segs=%b, want an=1110 segs=0000001", an, segs);
    end
  endtask

  task automatic test_decode_sweep();
    logic [6:0] want [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    @(negedge clock);
    reset = 1'b1;
    for (int v = 0; v < 16; v++) begin
      @(negedge clock);
      in0 = 4'(v);
      #1;
      checks++;
      if (an !== 4'b1110 || segs !== want[v]) begin
        errors++;
        $display("FAIL decode_%h: an=%b segs=%b, want an=1110 segs=%b", v, an, segs, want[v]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_live_update();
    in0 = 4'h0; in1 = 4'h8;
    do_reset();
    repeat (4) @(negedge clock);
    #1;
    checks++;
    if (an !== 4'b1101 || segs !== 7'b0000000) begin
      errors++;
      $display("FAIL live_before: an=%b segs=%b, want an=1101 segs=0000000", an, segs);
    end
    in1 = 4'hE;
    #1;
    checks++;
    if (an !== 4'b1101 || segs !== 7'b0110000) begin
      errors++;
      $display("FAIL live_after: an=%b segs=%b, want an=1101 segs=0110000", an, segs);
    end
  endtask

  task automatic test_reset_mid_scan();
    in0 = 4'h5; in1 = 4'h6; in2 = 4'h7; in3 = 4'h9;
    do_reset();
    repeat (8) @(negedge clock);
    #1;
    checks++;
    if (an !== 4'b1011 || segs !== 7'b0001111) begin
      errors++;
      $display("FAIL mid_before: an=%b segs=%b, want an=1011 segs=0001111", an, segs);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1110 || segs !== 7'b0100100) begin
      errors++;
      $display("FAIL mid_reset: an=%b segs=%b, want an=1110 segs=0100100", an, segs);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      #1;
      checks++;
      if (an !== 4'b1110) begin
        errors++;
        $display("FAIL mid_slot0_%0d: an=%b, want 1110", k, an);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (an !== 4'b1101 || segs !== 7'b0100000) begin
      errors++;
      $display("FAIL mid_slot1: an=%b segs=%b, want an=1101 segs=0100000", an, segs);
    end
  endtask

  task automatic test_one_cold();
    logic [3:0] cnt;
    logic [3:0] want_an;
    logic [3:0] nib;
    do_reset();
    cnt = 4'd0;
    for (int i = 0; i < 1000; i++) begin
      in0 = 4'($urandom_range(0, 15));
      in1 = 4'($urandom_range(0, 15));
      in2 = 4'($urandom_range(0, 15));
      in3 = 4'($urandom_range(0, 15));
      #1;
      case (cnt[3:2])
        2'd0: begin want_an = 4'b1110; nib = in0; end
        2'd1: begin want_an = 4'b1101; nib = in1; end
        2'd2: begin want_an = 4'b1011; nib = in2; end
        default: begin want_an = 4'b0111; nib = in3; end
      endcase
      checks++;
      if ($countones(~an) != 1 || dp !== 1'b1 || an !== want_an || segs !== dec(nib)) begin
        errors++;
        $display("FAIL one_cold_%0d: an=%b dp=%b segs=%b, want an=%b dp=1 segs=%b",
                 i, an, dp, segs, want_an, dec(nib));
      end
      @(negedge clock);
      cnt = cnt + 4'd1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    in0 = 4'h0; in1 = 4'h0; in2 = 4'h0; in3 = 4'h0;
    test_reset();
    test_decode_sweep();
    test_live_update();
    test_reset_mid_scan();
    test_one_cold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
